// File: rtl/demo_sequencer.sv
// Scene scheduler: counts frames, walks scenes through fade-in / play / fade-out,
// and takes skip (rising edge) and pause (level) requests from raw pins.
module demo_sequencer #(
    parameter int SCENE_BITS   = 3,
    parameter int NUM_SCENES   = 6,
    parameter int FRAME_BITS   = 10,
    parameter int SCENE_FRAMES = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [1:0]            advance,
    output logic [SCENE_BITS-1:0] scene,
    output logic [FRAME_BITS-1:0] scene_frame,
    output logic [3:0]            fade,
    output logic                  scene_change,
    output logic                  paused
);

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        PLAY     = 2'd1,
        FADE_OUT = 2'd2
    } state_t;

    localparam logic [SCENE_BITS-1:0] LAST_SCENE = SCENE_BITS'(NUM_SCENES - 1);
    localparam logic [FRAME_BITS-1:0] LAST_FRAME = FRAME_BITS'(SCENE_FRAMES - 1);
    localparam logic [3:0]            FADE_MAX   = 4'd15;

    // Saturating helpers keep the counters from wrapping.
    function automatic logic [FRAME_BITS-1:0] frame_sat_inc(input logic [FRAME_BITS-1:0] v);
        return (&v) ? v : v + FRAME_BITS'(1);
    endfunction

    function automatic logic [3:0] fade_sat_inc(input logic [3:0] v);
        return (v == FADE_MAX) ? v : v + 4'd1;
    endfunction

    function automatic logic [3:0] fade_sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    function automatic logic [SCENE_BITS-1:0] scene_wrap_inc(input logic [SCENE_BITS-1:0] v);
        return (v == LAST_SCENE) ? '0 : v + SCENE_BITS'(1);
    endfunction

    logic [1:0]            adv_p0;
    logic [1:0]            adv_p1;
    logic                  skip_d_p2;
    logic                  skip_pending;
    logic                  skip_edge;
    logic                  skip;
    logic                  step;

    state_t                state;
    state_t                state_nxt;
    logic [SCENE_BITS-1:0] scene_nxt;
    logic [FRAME_BITS-1:0] scene_frame_nxt;
    logic [3:0]            fade_nxt;
    logic                  scene_change_nxt;

    assign paused    = adv_p1[1];
    assign skip_edge = adv_p1[0] & ~skip_d_p2;
    assign skip      = skip_pending | skip_edge;
    assign step      = frame_start & ~paused;

    // Stage p0/p1: pin synchronizer; p2: skip edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adv_p0       <= 2'b00;
            adv_p1       <= 2'b00;
            skip_d_p2    <= 1'b0;
            skip_pending <= 1'b0;
        end else begin
            adv_p0    <= advance;
            adv_p1    <= adv_p0;
            skip_d_p2 <= adv_p1[0];
            if (step)
                skip_pending <= 1'b0;
            else if (skip_edge)
                skip_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FADE_IN;
            scene        <= '0;
            scene_frame  <= '0;
            fade         <= 4'd0;
            scene_change <= 1'b0;
        end else begin
            state        <= state_nxt;
            scene        <= scene_nxt;
            scene_frame  <= scene_frame_nxt;
            fade         <= fade_nxt;
            scene_change <= scene_change_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        scene_nxt        = scene;
        scene_frame_nxt  = scene_frame;
        fade_nxt         = fade;
        scene_change_nxt = 1'b0;
        if (step) begin
            scene_frame_nxt = frame_sat_inc(scene_frame);
            case (state)
                FADE_IN: begin
                    if (skip) begin
                        state_nxt = FADE_OUT;
                    end else begin
                        fade_nxt = fade_sat_inc(fade);
                        if (fade_sat_inc(fade) == FADE_MAX)
                            state_nxt = PLAY;
                    end
                end
                PLAY: begin
                    if (skip || (scene_frame == LAST_FRAME))
                        state_nxt = FADE_OUT;
                end
                FADE_OUT: begin
                    if (fade != 4'd0) begin
                        fade_nxt = fade_sat_dec(fade);
                    end else begin
                        // Scene switch: restart the frame count at the new scene
                        scene_nxt        = scene_wrap_inc(scene);
                        scene_frame_nxt  = '0;
                        scene_change_nxt = 1'b1;
                        state_nxt        = FADE_IN;
                    end
                end
                default: state_nxt = FADE_IN;
            endcase
        end
    end

endmodule

// File: tb/tb_demo_sequencer.sv
// Bench for demo_sequencer: checkpoint table from reset plus hand sequences for
// skip hold, pause and asynchronous reset, with a per-step model scoreboard.
module tb_demo_sequencer;

    localparam int SB = 3;
    localparam int NS = 3;
    localparam int FB = 10;
    localparam int SF = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [1:0]    advance = 2'b00;
    logic [SB-1:0] scene;
    logic [FB-1:0] scene_frame;
    logic [3:0]    fade;
    logic          scene_change;
    logic          paused;

    demo_sequencer #(
        .SCENE_BITS  (SB),
        .NUM_SCENES  (NS),
        .FRAME_BITS  (FB),
        .SCENE_FRAMES(SF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .advance     (advance),
        .scene       (scene),
        .scene_frame (scene_frame),
        .fade        (fade),
        .scene_change(scene_change),
        .paused      (paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        int scene;
        int sf;
        int fade;
        int change;
        int paused;
    } exp_t;

    typedef struct {
        int steps_total;
        int scene;
        int sf;
        int fade;
        int changes;
    } chk_t;

    exp_t sbq[$];
    chk_t tbl[8];

    int n_checks = 0;
    int n_fail = 0;
    int change_count = 0;
    int steps_done = 0;

    // Reference model: 0 = fade in, 1 = play, 2 = fade out
    int m_state, m_scene, m_sf, m_fade, m_skip, m_paused;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_scene = 0; m_sf = 0; m_fade = 0; m_skip = 0; m_paused = 0;
    endtask

    task automatic model_step(output exp_t e);
        int sk;
        e.change = 0;
        if (m_paused == 0) begin
            sk = m_skip;
            m_skip = 0;
            if (m_state == 0) begin
                m_sf = (m_sf == (1 << FB) - 1) ? m_sf : m_sf + 1;
                if (sk != 0) m_state = 2;
                else begin
                    m_fade = m_fade + 1;
                    if (m_fade == 15) m_state = 1;
                end
            end else if (m_state == 1) begin
                if (sk != 0 || m_sf == SF - 1) m_state = 2;
                m_sf = (m_sf == (1 << FB) - 1) ? m_sf : m_sf + 1;
            end else begin
                if (m_fade != 0) begin
                    m_fade = m_fade - 1;
                    m_sf = (m_sf == (1 << FB) - 1) ? m_sf : m_sf + 1;
                end else begin
                    m_scene = (m_scene == NS - 1) ? 0 : m_scene + 1;
                    m_sf = 0;
                    e.change = 1;
                    m_state = 0;
                end
            end
        end
        e.scene = m_scene;
        e.sf = m_sf;
        e.fade = m_fade;
        e.paused = m_paused;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        check("scene", int'(scene), e.scene);
        check("scene_frame", int'(scene_frame), e.sf);
        check("fade", int'(fade), e.fade);
        check("scene_change", int'(scene_change), e.change);
        check("paused", int'(paused), e.paused);
        check("scene_range", (int'(scene) < NS) ? 1 : 0, 1);
        if (scene_change) change_count++;
        if (e.change == 1) begin
            @(negedge clk);
            check("scene_change_width", int'(scene_change), 0);
        end
    endtask

    task automatic do_step();
        exp_t e;
        @(negedge clk);
        frame_start = 1'b1;
        model_step(e);
        sbq.push_back(e);
        @(negedge clk);
        frame_start = 1'b0;
        steps_done++;
        compare_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        advance = 2'b00;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        sbq.delete();
        steps_done = 0;
        change_count = 0;
        @(negedge clk);
    endtask

    task automatic set_pause(input int v);
        @(negedge clk);
        advance[1] = v[0];
        repeat (4) @(negedge clk);
        m_paused = v;
        check("paused_sync", int'(paused), v);
    endtask

    task automatic skip_pulse();
        @(negedge clk);
        advance[0] = 1'b1;
        repeat (4) @(negedge clk);
        m_skip = 1;
        advance[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_scene"}, int'(scene), 0);
        check({tag, "_scene_frame"}, int'(scene_frame), 0);
        check({tag, "_fade"}, int'(fade), 0);
        check({tag, "_scene_change"}, int'(scene_change), 0);
        check({tag, "_paused"}, int'(paused), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{15,  0, 15, 15, 0};
        tbl[1] = '{20,  0, 20, 15, 0};
        tbl[2] = '{21,  0, 21, 14, 0};
        tbl[3] = '{35,  0, 35,  0, 0};
        tbl[4] = '{36,  1,  0,  0, 1};
        tbl[5] = '{51,  1, 15, 15, 1};
        tbl[6] = '{72,  2,  0,  0, 2};
        tbl[7] = '{108, 0,  0,  0, 3};

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        // Scenes 1-3: nominal run from reset against checkpoint table
        for (int i = 0; i < 8; i++) begin
            while (steps_done < tbl[i].steps_total) do_step();
            check($sformatf("tbl%0d_scene", i), int'(scene), tbl[i].scene);
            check($sformatf("tbl%0d_scene_frame", i), int'(scene_frame), tbl[i].sf);
            check($sformatf("tbl%0d_fade", i), int'(fade), tbl[i].fade);
            check($sformatf("tbl%0d_changes", i), change_count, tbl[i].changes);
        end

        // Scenario 4: skip held high for 50 cycles during play
        do_reset();
        repeat (16) do_step();
        check("hold_pre_sf", int'(scene_frame), 16);
        advance[0] = 1'b1;
        repeat (50) @(negedge clk);
        m_skip = 1;
        do_step();
        check("hold_fadeout_fade", int'(fade), 15);
        check("hold_fadeout_sf", int'(scene_frame), 17);
        repeat (15) do_step();
        check("hold_fade_zero", int'(fade), 0);
        check("hold_scene_still0", int'(scene), 0);
        do_step();
        check("hold_switch_scene", int'(scene), 1);
        do_step();
        check("hold_single_skip_fade", int'(fade), 1);
        advance[0] = 1'b0;

        // Scenario 5: pause freezes outputs and keeps a skip pending
        do_reset();
        repeat (16) do_step();
        set_pause(1);
        skip_pulse();
        repeat (5) do_step();
        check("pause_sf_frozen", int'(scene_frame), 16);
        check("pause_fade_frozen", int'(fade), 15);
        check("pause_level", int'(paused), 1);
        set_pause(0);
        do_step();
        check("unpause_skip_fade", int'(fade), 15);
        check("unpause_skip_sf", int'(scene_frame), 17);
        do_step();
        check("unpause_fadeout", int'(fade), 14);

        // Scenario 6: asynchronous reset mid fade-out with a skip pending
        do_reset();
        repeat (100) do_step();
        check("pre_areset_fade", int'(fade), 7);
        check("pre_areset_scene", int'(scene), 2);
        skip_pulse();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("areset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sbq.delete();
        steps_done = 0;
        do_step();
        check("post_areset_fade", int'(fade), 1);
        check("post_areset_sf", int'(scene_frame), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
